comparador_serie: RTL

- Bit-serial N-bit magnitude comparator built around a 1-bit compare stage.
- Captures two N-bit operands on a start request, then shifts them MSB-first into the 1-bit compare, one bit pair per clock.
- Stops at the first differing bit and registers a one-hot mayor/igual/menor result with a single-cycle done pulse.
- Sits upstream of any consumer of comparison flags and is the multi-bit, sequential extension of the single-bit comparator.

---
 rtl/comparador_serie.sv | 102 ++++++++++
 1 files changed

// File: rtl/comparador_serie.sv
// Bit-serial unsigned magnitude comparator: walks the operands MSB-first through a
// 1-bit compare stage and stops at the first differing bit pair.
module comparador_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         mayor,
  output logic         igual,
  output logic         menor,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;

  // Current MSB pair feeding the 1-bit compare stage.
  logic x;
  logic y;
  assign x = sa[N-1];
  assign y = sb[N-1];

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      mayor <= 1'b0;
      igual <= 1'b0;
      menor <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            cnt   <= '0;
            mayor <= 1'b0;
            igual <= 1'b0;
            menor <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= COMP;
          end else begin
            // Results deliberately left untouched so they persist while idle.
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        COMP: begin
          if (x && !y) begin
            mayor <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!x && y) begin
            menor <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cnt == LAST) begin
            igual <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= {sa[N-2:0], 1'b0};
            sb  <= {sb[N-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end
        end

        // NOTE: unreachable encoding recovers to IDLE instead of locking up.
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
